// File: rtl/spi_target_pkg.sv
// Shared definitions for the SPI target block.
//   spi_target_state_e : FSM state encoding (IDLE, SHIFT)
//   MinSckRatio        : minimum clk_i / SCK frequency ratio the design tolerates
//   MinSyncStages      : minimum synchroniser depth on the pad inputs
package spi_target_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_target_state_e;

  localparam int unsigned MinSckRatio   = 8;
  localparam int unsigned MinSyncStages = 2;

endpackage

// File: rtl/spi_target_sync.sv
// Pad synchroniser and edge detector for the SPI target.
// Ports:
//   clk_i, rst_i            : system clock, async active-high reset
//   spi_sck_i/cs_ni/copi_i  : raw pad inputs from the external initiator
//   cs_n_sync, copi_sync    : synchronised levels
//   sck_rise/sck_fall       : single-cycle SCK edge strobes
//   cs_fall/cs_rise         : single-cycle chip-select edge strobes
module spi_target_sync
  import spi_target_pkg::*;
#(
  parameter int unsigned SyncStages = MinSyncStages
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic spi_sck_i,
  input  logic spi_cs_ni,
  input  logic spi_copi_i,
  output logic cs_n_sync,
  output logic copi_sync,
  output logic sck_rise,
  output logic sck_fall,
  output logic cs_fall,
  output logic cs_rise
);

  if (SyncStages < MinSyncStages) begin : g_bad_sync
    $error("spi_target_sync: SyncStages must be at least %0d", MinSyncStages);
  end

  // Bit order within each stage: {copi, cs_n, sck}.
  logic [SyncStages-1:0][2:0] stages_q;
  logic [2:0]                 pads;
  logic [2:0]                 last;
  logic                       sck_prev_q;
  logic                       cs_n_prev_q;

  assign pads = {spi_copi_i, spi_cs_ni, spi_sck_i};
  assign last = stages_q[SyncStages-1];

  // CS resets to "asserted" on purpose: if reset lands while the pad is
  // still low, no cs_fall can appear afterwards, so a new frame needs a
  // genuine high-to-low transition on the pad.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stages_q    <= '0;
      sck_prev_q  <= 1'b0;
      cs_n_prev_q <= 1'b0;
    end else begin
      stages_q    <= {stages_q[SyncStages-2:0], pads};
      sck_prev_q  <= last[0];
      cs_n_prev_q <= last[1];
    end
  end

  assign cs_n_sync = last[1];
  assign copi_sync = last[2];
  assign sck_rise  = last[0] & ~sck_prev_q;
  assign sck_fall  = ~last[0] & sck_prev_q;
  assign cs_fall   = ~last[1] & cs_n_prev_q;
  assign cs_rise   = last[1] & ~cs_n_prev_q;

endmodule

// File: rtl/spi_target.sv
// SPI target (responder), mode 0, MSB first.
// Ports:
//   clk_i, rst_i              : system clock, async active-high reset
//   spi_sck_i, spi_cs_ni      : SPI clock and active-low chip select from the initiator
//   spi_copi_i / spi_cipo_o   : serial data in / out
//   spi_cipo_en_o             : tristate enable for spi_cipo_o
//   tx_data_i, tx_valid_i     : one-entry TX buffer write port
//   tx_ready_o                : TX buffer empty
//   rx_data_o, rx_valid_o     : last complete received word, one-cycle strobe per frame
//   tx_underrun_o             : pulse when IdleFill is loaded for lack of TX data
//   frame_abort_o             : pulse when CS deasserts mid-frame
//   busy_o                    : high while a CS window is active
//
// state | meaning
// IDLE  | CS deasserted, CIPO released, waiting for cs_fall
// SHIFT | CS asserted, sampling COPI on SCK rise, driving CIPO on SCK fall
module spi_target
  import spi_target_pkg::*;
#(
  parameter int unsigned           FrameWidth = 8,
  parameter int unsigned           SyncStages = 2,
  parameter logic [FrameWidth-1:0] IdleFill   = '1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  spi_sck_i,
  input  logic                  spi_cs_ni,
  input  logic                  spi_copi_i,
  output logic                  spi_cipo_o,
  output logic                  spi_cipo_en_o,
  input  logic [FrameWidth-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [FrameWidth-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic                  tx_underrun_o,
  output logic                  frame_abort_o,
  output logic                  busy_o
);

  if (FrameWidth < 2) begin : g_bad_width
    $error("spi_target: FrameWidth must be at least 2");
  end

  localparam int unsigned     CntW    = $clog2(FrameWidth);
  localparam logic [CntW-1:0] LastBit = CntW'(FrameWidth - 1);

  logic cs_n_sync, copi_sync;
  logic sck_rise, sck_fall, cs_fall, cs_rise;

  spi_target_sync #(
    .SyncStages(SyncStages)
  ) u_sync (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .spi_sck_i (spi_sck_i),
    .spi_cs_ni (spi_cs_ni),
    .spi_copi_i(spi_copi_i),
    .cs_n_sync (cs_n_sync),
    .copi_sync (copi_sync),
    .sck_rise  (sck_rise),
    .sck_fall  (sck_fall),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise)
  );

  spi_target_state_e state_q, state_d;

  logic [CntW-1:0]       bit_cnt_q;
  logic [FrameWidth-1:0] tx_shift_q;
  logic [FrameWidth-1:0] rx_shift_q;
  logic [FrameWidth-1:0] rx_data_q;
  logic [FrameWidth-1:0] tx_buf_q;
  logic                  tx_full_q;
  logic                  rx_valid_q, tx_underrun_q, frame_abort_q;

  logic load_tx, shift_tx, shift_rx, frame_done, go_idle, abort;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // cs_rise is tested first so that an SCK edge landing in the same
  // synchronised cycle is dropped.
  always_comb begin
    state_d    = state_q;
    load_tx    = 1'b0;
    shift_tx   = 1'b0;
    shift_rx   = 1'b0;
    frame_done = 1'b0;
    go_idle    = 1'b0;
    abort      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = SHIFT;
          load_tx = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d = IDLE;
          go_idle = 1'b1;
          abort   = (bit_cnt_q != '0);
        end else if (sck_rise && !cs_n_sync) begin
          shift_rx   = 1'b1;
          frame_done = (bit_cnt_q == LastBit);
        end else if (sck_fall && !cs_n_sync) begin
          if (bit_cnt_q != '0) shift_tx = 1'b1;
          else                 load_tx  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic                  tx_accept;
  logic                  underrun;
  logic [FrameWidth-1:0] load_word;
  logic [FrameWidth-1:0] rx_word;

  // A load and a handshake in the same cycle with an empty buffer: the load
  // sees the buffer as empty (IdleFill) and the new word waits for the next frame.
  assign tx_accept = tx_valid_i & ~tx_full_q;
  assign underrun  = load_tx & ~tx_full_q;
  assign load_word = tx_full_q ? tx_buf_q : IdleFill;
  assign rx_word   = {rx_shift_q[FrameWidth-2:0], copi_sync};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bit_cnt_q     <= '0;
      tx_shift_q    <= IdleFill;
      rx_shift_q    <= '0;
      rx_data_q     <= '0;
      tx_buf_q      <= '0;
      tx_full_q     <= 1'b0;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      rx_valid_q    <= frame_done;
      tx_underrun_q <= underrun;
      frame_abort_q <= abort;

      if (load_tx)       tx_shift_q <= load_word;
      else if (shift_tx) tx_shift_q <= {tx_shift_q[FrameWidth-2:0], 1'b0};

      if (shift_rx) begin
        rx_shift_q <= rx_word;
        bit_cnt_q  <= frame_done ? '0 : bit_cnt_q + CntW'(1);
      end else if (go_idle) begin
        bit_cnt_q <= '0;
      end

      if (frame_done) rx_data_q <= rx_word;

      if (tx_accept) begin
        tx_buf_q  <= tx_data_i;
        tx_full_q <= 1'b1;
      end else if (load_tx) begin
        tx_full_q <= 1'b0;
      end
    end
  end

  assign busy_o        = (state_q == SHIFT);
  assign spi_cipo_en_o = busy_o;
  assign spi_cipo_o    = busy_o ? tx_shift_q[FrameWidth-1] : 1'b1;
  assign tx_ready_o    = ~tx_full_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign tx_underrun_o = tx_underrun_q;
  assign frame_abort_o = frame_abort_q;

endmodule
